// File: rtl/vga_timing_gen_pkg.sv
// Video mode description, standard mode presets and axis-total helpers.
// Shared by the timing generator and its per-axis counters.
package vga_pkg;

    typedef struct packed {
        logic [15:0] h_active;
        logic [15:0] h_front;
        logic [15:0] h_sync;
        logic [15:0] h_back;
        logic [15:0] v_active;
        logic [15:0] v_front;
        logic [15:0] v_sync;
        logic [15:0] v_back;
    } vga_timing_t;

    typedef enum logic {
        AXIS_H = 1'b0,
        AXIS_V = 1'b1
    } vga_axis_e;

    localparam vga_timing_t VGA_640x480_60 = '{
        16'd640,  16'd16, 16'd96,  16'd48,
        16'd480,  16'd10, 16'd2,   16'd33
    };
    localparam vga_timing_t SVGA_800x600_60 = '{
        16'd800,  16'd40, 16'd128, 16'd88,
        16'd600,  16'd1,  16'd4,   16'd23
    };
    localparam vga_timing_t XGA_1024x768_60 = '{
        16'd1024, 16'd24, 16'd136, 16'd160,
        16'd768,  16'd3,  16'd6,   16'd29
    };

    function automatic int axis_total(input int act, input int fp, input int sw, input int bp);
        return act + fp + sw + bp;
    endfunction

    function automatic int total(input vga_timing_t t, input vga_axis_e ax);
        if (ax == AXIS_H)
            return axis_total(int'(t.h_active), int'(t.h_front), int'(t.h_sync), int'(t.h_back));
        else
            return axis_total(int'(t.v_active), int'(t.v_front), int'(t.v_sync), int'(t.v_back));
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: pixel enable in, sync/enable/coordinate/strobe outputs.
// Generator drives through master; consumers (line buffers, pixel pipe) use slave.
interface vga_timing_gen_if #(
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 19
);
    logic              ce;
    logic              hs;
    logic              vs;
    logic              de;
    logic [CNT_W-1:0]  x;
    logic [CNT_W-1:0]  y;
    logic [ADDR_W-1:0] pixel;
    logic              sol;
    logic              eol;
    logic              sof;
    logic              eof;
    logic              line_req;
    logic [CNT_W-1:0]  line_y;
    logic [15:0]       frame_cnt;

    modport master (
        input  ce,
        output hs, vs, de, x, y, pixel, sol, eol, sof, eof, line_req, line_y, frame_cnt
    );

    modport slave (
        output ce,
        input  hs, vs, de, x, y, pixel, sol, eol, sof, eof, line_req, line_y, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// One timing axis: wrapping position counter plus region decode of the next position.
// cnt_nxt and the *_nxt flags are combinational; the count advances only when inc=1.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FRONT  = 16,
    parameter int SYNC   = 96,
    parameter int BACK   = 48,
    parameter int CNT_W  = 16
) (
    input  logic             clock,
    input  logic             rst_i,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             wrap,
    output logic             first_nxt,
    output logic             act_nxt,
    output logic             sync_nxt,
    output logic             last_nxt
);

    localparam int TOTAL = axis_total(ACTIVE, FRONT, SYNC, BACK);

    localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_C     = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_LO_C = CNT_W'(ACTIVE + FRONT);
    localparam logic [CNT_W-1:0] SYNC_HI_C = CNT_W'(ACTIVE + FRONT + SYNC);

    if (longint'(TOTAL) > ((longint'(1) << CNT_W) - 1)) begin : g_total_check
        $error("vga_axis_counter: axis total %0d does not fit in CNT_W=%0d", TOTAL, CNT_W);
    end

    logic [CNT_W-1:0] cnt;

    assign wrap = inc && (cnt == LAST_C);

    always_comb begin
        cnt_nxt = cnt;
        if (inc) begin
            cnt_nxt = (cnt == LAST_C) ? '0 : cnt + 1'b1;
        end
    end

    assign first_nxt = (cnt_nxt == '0);
    assign act_nxt   = (cnt_nxt < ACT_C);
    assign sync_nxt  = (cnt_nxt >= SYNC_LO_C) && (cnt_nxt < SYNC_HI_C);
    assign last_nxt  = (cnt_nxt == LAST_C);

    always_ff @(posedge clock) begin
        if (rst_i) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VESA-style timing generator; all outputs registered, zero latency to (h,v).
// No backpressure: ce=0 freezes every register, strobes included.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int PREFETCH = 32,
    parameter int CNT_W    = 16,
    parameter int ADDR_W   = 19
) (
    input  logic               clock,
    input  logic               rst_i,
    vga_timing_gen_if.master   vif
);

    localparam vga_timing_t MODE = '{
        16'(H_ACTIVE), 16'(H_FRONT), 16'(H_SYNC), 16'(H_BACK),
        16'(V_ACTIVE), 16'(V_FRONT), 16'(V_SYNC), 16'(V_BACK)
    };
    localparam int H_TOTAL = total(MODE, AXIS_H);

    localparam logic [CNT_W-1:0] REQ_H_C   = CNT_W'(H_TOTAL - PREFETCH);
    localparam logic [CNT_W-1:0] V_ACT_C   = CNT_W'(V_ACTIVE);
    localparam logic             HS_ON     = 1'(HS_POL);
    localparam logic             VS_ON     = 1'(VS_POL);

    if (PREFETCH < 1 || PREFETCH > H_FRONT + H_SYNC + H_BACK) begin : g_prefetch_check
        $error("vga_timing_gen: PREFETCH=%0d outside 1..%0d", PREFETCH, H_FRONT + H_SYNC + H_BACK);
    end

    logic [CNT_W-1:0] h_nxt, v_nxt;
    logic             h_wrap, v_wrap;
    logic             h_first_n, v_first_n;
    logic             h_act_n, v_act_n;
    logic             h_sync_n, v_sync_n;
    logic             h_last_n, v_last_n;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK),
        .CNT_W  (CNT_W)
    ) u_h (
        .clock     (clock),
        .rst_i     (rst_i),
        .inc       (vif.ce),
        .cnt_nxt   (h_nxt),
        .wrap      (h_wrap),
        .first_nxt (h_first_n),
        .act_nxt   (h_act_n),
        .sync_nxt  (h_sync_n),
        .last_nxt  (h_last_n)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK),
        .CNT_W  (CNT_W)
    ) u_v (
        .clock     (clock),
        .rst_i     (rst_i),
        .inc       (h_wrap),
        .cnt_nxt   (v_nxt),
        .wrap      (v_wrap),
        .first_nxt (v_first_n),
        .act_nxt   (v_act_n),
        .sync_nxt  (v_sync_n),
        .last_nxt  (v_last_n)
    );

    logic             de_n;
    logic             sof_n;
    logic [CNT_W-1:0] line_nxt;
    logic             req_n;

    assign de_n     = h_act_n && v_act_n;
    assign sof_n    = h_first_n && v_first_n;
    // The line after the last one of the frame is line 0, requested from back porch.
    assign line_nxt = v_last_n ? '0 : v_nxt + 1'b1;
    assign req_n    = (h_nxt == REQ_H_C) && (line_nxt < V_ACT_C);

    always_ff @(posedge clock) begin
        if (rst_i) begin
            vif.hs        <= ~HS_ON;
            vif.vs        <= ~VS_ON;
            vif.de        <= 1'b1;
            vif.x         <= '0;
            vif.y         <= '0;
            vif.pixel     <= '0;
            vif.sol       <= 1'b1;
            vif.eol       <= 1'b0;
            vif.sof       <= 1'b1;
            vif.eof       <= 1'b0;
            vif.line_req  <= 1'b0;
            vif.line_y    <= '0;
            vif.frame_cnt <= '0;
        end else if (vif.ce) begin
            vif.hs       <= h_sync_n ? HS_ON : ~HS_ON;
            vif.vs       <= v_sync_n ? VS_ON : ~VS_ON;
            vif.de       <= de_n;
            vif.x        <= de_n ? h_nxt : '0;
            vif.y        <= v_act_n ? v_nxt : '0;
            vif.sol      <= h_first_n && v_act_n;
            vif.eol      <= h_last_n;
            vif.sof      <= sof_n;
            vif.eof      <= h_last_n && v_last_n;
            vif.line_req <= req_n;
            vif.line_y   <= req_n ? line_nxt : '0;
            // Every visible pixel but (0,0) follows exactly one increment, so no multiply is needed.
            if (sof_n) begin
                vif.pixel <= '0;
            end else if (de_n) begin
                vif.pixel <= vif.pixel + 1'b1;
            end
            if (v_wrap) begin
                vif.frame_cnt <= vif.frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: small 16x8 mode (both sync polarities), ce throttling, mid-frame reset,
// and the opening lines of the default 640x480 mode.
module tb_vga_timing_gen;

    typedef struct {
        int   step;
        logic de, hs, vs, sol, eol, sof, eof, lreq;
        int   x, y, pixel, line_y, fcnt;
    } vec_t;

    logic clock;
    logic rst;
    logic rst_c;
    int   n_vec = 0;
    int   n_err = 0;
    int   nc    = 0;

    vga_timing_gen_if #(.CNT_W(16), .ADDR_W(19)) if_a ();
    vga_timing_gen_if #(.CNT_W(16), .ADDR_W(19)) if_b ();
    vga_timing_gen_if #(.CNT_W(16), .ADDR_W(19)) if_c ();

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HS_POL(0), .VS_POL(0), .PREFETCH(4), .CNT_W(16), .ADDR_W(19)
    ) dut_a (.clock(clock), .rst_i(rst), .vif(if_a));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HS_POL(1), .VS_POL(1), .PREFETCH(4), .CNT_W(16), .ADDR_W(19)
    ) dut_b (.clock(clock), .rst_i(rst), .vif(if_b));

    vga_timing_gen dut_c (.clock(clock), .rst_i(rst_c), .vif(if_c));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, want run complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input logic c);
        if_a.ce = c;
        if_b.ce = c;
        @(posedge clock);
        #1;
    endtask

    // Reference for the 16x8 mode, derived from the ce count since reset.
    function automatic vec_t model(input int n);
        vec_t e;
        int h = n % 16;
        int v = (n / 16) % 8;
        int nl = (v + 1) % 8;
        e.step   = n;
        e.de     = (h < 8) && (v < 4);
        e.x      = e.de ? h : 0;
        e.y      = (v < 4) ? v : 0;
        e.pixel  = (v < 4) ? (v * 8 + ((h < 8) ? h : 7)) : 31;
        e.hs     = !((h >= 10) && (h < 13));
        e.vs     = !((v >= 5) && (v < 7));
        e.sol    = (h == 0) && (v < 4);
        e.eol    = (h == 15);
        e.sof    = (h == 0) && (v == 0);
        e.eof    = (h == 15) && (v == 7);
        e.lreq   = (h == 12) && (nl < 4);
        e.line_y = e.lreq ? nl : 0;
        e.fcnt   = n / 128;
        return e;
    endfunction

    task automatic check_a(input string tag, input vec_t e);
        chk({tag, " de"},    32'(if_a.de),    32'(e.de));
        chk({tag, " hs"},    32'(if_a.hs),    32'(e.hs));
        chk({tag, " vs"},    32'(if_a.vs),    32'(e.vs));
        chk({tag, " sol"},   32'(if_a.sol),   32'(e.sol));
        chk({tag, " eol"},   32'(if_a.eol),   32'(e.eol));
        chk({tag, " sof"},   32'(if_a.sof),   32'(e.sof));
        chk({tag, " eof"},   32'(if_a.eof),   32'(e.eof));
        chk({tag, " lreq"},  32'(if_a.line_req), 32'(e.lreq));
        chk({tag, " x"},     32'(if_a.x),     e.x);
        chk({tag, " y"},     32'(if_a.y),     e.y);
        chk({tag, " pixel"}, 32'(if_a.pixel), e.pixel);
        chk({tag, " fcnt"},  32'(if_a.frame_cnt), e.fcnt);
        if (e.lreq) chk({tag, " line_y"}, 32'(if_a.line_y), e.line_y);
        chk({tag, " b_hs"},  32'(if_b.hs),    32'(!e.hs));
        chk({tag, " b_vs"},  32'(if_b.vs),    32'(!e.vs));
        chk({tag, " b_de"},  32'(if_b.de),    32'(e.de));
    endtask

    task automatic run_c(input int target);
        while (nc < target) begin
            tick(1'b1);
            nc++;
        end
    endtask

    vec_t tbl[19];

    initial begin
        int cur;
        int n;
        //         step  de hs vs sol eol sof eof lrq  x  y  pix ly f
        tbl[0]  = '{0,   1, 1, 1, 1,  0,  1,  0,  0,   0, 0, 0,  0, 0};
        tbl[1]  = '{7,   1, 1, 1, 0,  0,  0,  0,  0,   7, 0, 7,  0, 0};
        tbl[2]  = '{8,   0, 1, 1, 0,  0,  0,  0,  0,   0, 0, 7,  0, 0};
        tbl[3]  = '{10,  0, 0, 1, 0,  0,  0,  0,  0,   0, 0, 7,  0, 0};
        tbl[4]  = '{12,  0, 0, 1, 0,  0,  0,  0,  1,   0, 0, 7,  1, 0};
        tbl[5]  = '{13,  0, 1, 1, 0,  0,  0,  0,  0,   0, 0, 7,  0, 0};
        tbl[6]  = '{15,  0, 1, 1, 0,  1,  0,  0,  0,   0, 0, 7,  0, 0};
        tbl[7]  = '{16,  1, 1, 1, 1,  0,  0,  0,  0,   0, 1, 8,  0, 0};
        tbl[8]  = '{28,  0, 0, 1, 0,  0,  0,  0,  1,   0, 1, 15, 2, 0};
        tbl[9]  = '{44,  0, 0, 1, 0,  0,  0,  0,  1,   0, 2, 23, 3, 0};
        tbl[10] = '{59,  0, 0, 1, 0,  0,  0,  0,  0,   0, 3, 31, 0, 0};
        tbl[11] = '{60,  0, 0, 1, 0,  0,  0,  0,  0,   0, 3, 31, 0, 0};
        tbl[12] = '{80,  0, 1, 0, 0,  0,  0,  0,  0,   0, 0, 31, 0, 0};
        tbl[13] = '{92,  0, 0, 0, 0,  0,  0,  0,  0,   0, 0, 31, 0, 0};
        tbl[14] = '{112, 0, 1, 1, 0,  0,  0,  0,  0,   0, 0, 31, 0, 0};
        tbl[15] = '{124, 0, 0, 1, 0,  0,  0,  0,  1,   0, 0, 31, 0, 0};
        tbl[16] = '{127, 0, 1, 1, 0,  1,  0,  1,  0,   0, 0, 31, 0, 0};
        tbl[17] = '{128, 1, 1, 1, 1,  0,  1,  0,  0,   0, 0, 0,  0, 1};
        tbl[18] = '{129, 1, 1, 1, 0,  0,  0,  0,  0,   1, 0, 1,  0, 1};

        if_c.ce = 1'b1;
        rst     = 1'b1;
        rst_c   = 1'b1;
        tick(1'b0);
        tick(1'b1);
        check_a("reset", model(0));
        rst = 1'b0;

        // Table of hand-computed positions, ce held high.
        cur = 0;
        for (int i = 0; i < 19; i++) begin
            while (cur < tbl[i].step) begin
                tick(1'b1);
                cur++;
            end
            check_a($sformatf("tbl%0d", tbl[i].step), tbl[i]);
        end

        // ce 1-in-3: outputs follow the ce count and hold in between.
        rst = 1'b1;
        tick(1'b1);
        rst = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 3 * 260; cyc++) begin
            logic c;
            c = (cyc % 3 == 0);
            tick(c);
            if (c) n++;
            check_a($sformatf("ce3 n%0d", n), model(n));
        end

        // Reset at (5,2) for two cycles, then a clean restart.
        rst = 1'b1;
        tick(1'b1);
        rst = 1'b0;
        for (int i = 0; i < 37; i++) tick(1'b1);
        check_a("pre_rst", model(37));
        rst = 1'b1;
        tick(1'b1);
        check_a("rst_held1", model(0));
        tick(1'b0);
        check_a("rst_held2", model(0));
        rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick(1'b1);
            check_a($sformatf("restart%0d", i), model(i));
        end

        // Default 640x480 mode: opening line and the start of the second.
        rst_c = 1'b0;
        nc = 0;
        chk("c sof0",   32'(if_c.sof), 1);
        chk("c de0",    32'(if_c.de), 1);
        chk("c hs0",    32'(if_c.hs), 1);
        run_c(639);
        chk("c x639",   32'(if_c.x), 639);
        chk("c pix639", 32'(if_c.pixel), 639);
        chk("c de639",  32'(if_c.de), 1);
        run_c(640);
        chk("c de640",  32'(if_c.de), 0);
        chk("c pix640", 32'(if_c.pixel), 639);
        run_c(655);
        chk("c hs655",  32'(if_c.hs), 1);
        run_c(656);
        chk("c hs656",  32'(if_c.hs), 0);
        run_c(751);
        chk("c hs751",  32'(if_c.hs), 0);
        run_c(752);
        chk("c hs752",  32'(if_c.hs), 1);
        run_c(767);
        chk("c lreq767", 32'(if_c.line_req), 0);
        run_c(768);
        chk("c lreq768", 32'(if_c.line_req), 1);
        chk("c ly768",   32'(if_c.line_y), 1);
        run_c(799);
        chk("c eol799", 32'(if_c.eol), 1);
        chk("c eof799", 32'(if_c.eof), 0);
        run_c(800);
        chk("c x800",   32'(if_c.x), 0);
        chk("c y800",   32'(if_c.y), 1);
        chk("c pix800", 32'(if_c.pixel), 640);
        chk("c sol800", 32'(if_c.sol), 1);
        chk("c sof800", 32'(if_c.sof), 0);
        chk("c fc800",  32'(if_c.frame_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
